// File: rtl/audio_pkg.sv
// Shared constants and helpers for the codec audio serial port.
package audio_pkg;

    localparam logic FMT_LJ  = 1'b0;
    localparam logic FMT_I2S = 1'b1;

    // Slot-relative bit position of the sample MSB.
    // Left-justified starts at bit 0. I2S is delayed by one bit clock.
    function automatic int msb_offset(input logic fmt);
        return (fmt == FMT_I2S) ? 1 : 0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head word is driven combinationally from registered storage.
// It reads as zero while the FIFO is empty.
// Empty and full follow the registered occupancy, so they change one cycle after a push or pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write. Contents are not reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/audio_serial_port.sv
// Codec audio serial port.
// Generates m_clk, b_clk and the L/R clock.
// Serialises {left,right} DAC words from a write FIFO.
// Deserialises ADC words into a read FIFO.
// Optional macro AUDIO_LOOPBACK_EN adds ADC-to-DAC loopback.
// With it, the captured word replaces the DAC FIFO pop at each frame boundary.
module audio_serial_port
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int MCLK_DIV = 2,
    parameter int BCLK_DIV = 4,
    parameter int FIFO_AW  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fmt,
    input  logic                  loopback,
    input  logic                  clr_flags,
    input  logic                  adcdat,
    output logic                  m_clk,
    output logic                  b_clk,
    output logic                  dac_lr_clk,
    output logic                  adc_lr_clk,
    output logic                  dacdat,
    input  logic [2*SAMPLE_W-1:0] dac_fifo_in,
    input  logic                  wr_dac_fifo,
    output logic                  dac_fifo_full,
    output logic [2*SAMPLE_W-1:0] adc_fifo_out,
    input  logic                  rd_adc_fifo,
    output logic                  adc_fifo_empty,
    output logic                  adc_fifo_full,
    output logic                  dac_underrun,
    output logic                  adc_overrun
);

    localparam int WORD_W  = 2*SAMPLE_W;
    localparam int FRAME_W = 2*SLOT_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int IDX_W   = $clog2(WORD_W);
    localparam int MDIV_W  = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int BDIV_W  = $clog2(BCLK_DIV);

    localparam logic [MDIV_W-1:0] MCLK_LAST = MDIV_W'(MCLK_DIV-1);
    localparam logic [BDIV_W-1:0] BCLK_LAST = BDIV_W'(BCLK_DIV-1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W-1);

    logic [MDIV_W-1:0] mclk_cnt;
    logic              m_clk_r;
    logic [BDIV_W-1:0] bdiv_cnt;
    logic              b_clk_r;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic              lr_r;
    logic              fmt_q;
    logic              fmt_nxt;
    logic              bdiv_wrap;
    logic              bclk_fall;
    logic              bclk_rise;
    logic              frame_tick;
    logic [WORD_W-1:0] tx_word;
    logic [WORD_W-1:0] tx_load;
    logic [WORD_W-1:0] cap_word;
    logic [WORD_W-1:0] dac_head;
    logic              dac_empty;
    logic              dac_pop;
    logic              dacdat_r;
    logic              underrun_set;
    logic              overrun_set;
    logic              dac_underrun_r;
    logic              adc_overrun_r;

    // Bit position inside the current channel slot.
    function automatic int slot_rel(input logic [BIT_W-1:0] pos);
        int p;
        p = int'(pos);
        return (p >= SLOT_W) ? p - SLOT_W : p;
    endfunction

    // True when this frame bit carries a sample bit, given the format.
    // Positions past the slot end are truncated.
    function automatic logic slot_hit(input logic [BIT_W-1:0] pos, input logic f);
        int k;
        k = slot_rel(pos) - msb_offset(f);
        return (k >= 0) && (k < SAMPLE_W);
    endfunction

    // Word bit index for a frame bit. Left is the upper half, right the lower half, MSB first.
    function automatic logic [IDX_W-1:0] slot_idx(input logic [BIT_W-1:0] pos, input logic f);
        int k;
        k = slot_rel(pos) - msb_offset(f);
        return (int'(pos) >= SLOT_W) ? IDX_W'(SAMPLE_W-1-k) : IDX_W'(WORD_W-1-k);
    endfunction

    // Serial bit to transmit at a frame position. Unused slot bits carry zero.
    function automatic logic slot_bit(input logic [WORD_W-1:0] word,
                                      input logic [BIT_W-1:0]  pos,
                                      input logic              f);
        return slot_hit(pos, f) ? word[slot_idx(pos, f)] : 1'b0;
    endfunction

    // L/R level for a frame position. In I2S mode it leads the slot by one bit clock.
    function automatic logic lr_of(input logic [BIT_W-1:0] pos, input logic f);
        int p;
        p = int'(pos);
        if (f == FMT_I2S) return (p >= SLOT_W-1) && (p < FRAME_W-1);
        return p >= SLOT_W;
    endfunction

    assign bdiv_wrap  = en && (bdiv_cnt == BCLK_LAST);
    assign bclk_fall  = bdiv_wrap && b_clk_r;
    assign bclk_rise  = bdiv_wrap && !b_clk_r;
    assign frame_tick = bclk_fall && (bit_cnt == BIT_LAST);
    assign bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    // Format is latched at the frame boundary, so the new frame sees the new value immediately.
    assign fmt_nxt    = frame_tick ? fmt : fmt_q;

    // Free-running master clock divider; keeps running while the port is disabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mclk_cnt <= '0;
            m_clk_r  <= 1'b0;
        end else if (mclk_cnt == MCLK_LAST) begin
            mclk_cnt <= '0;
            m_clk_r  <= ~m_clk_r;
        end else begin
            mclk_cnt <= mclk_cnt + 1'b1;
        end
    end

    // Bit-clock divider, frame bit counter and L/R framing; all cleared while disabled.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            bdiv_cnt <= '0;
            b_clk_r  <= 1'b0;
            bit_cnt  <= '0;
            lr_r     <= 1'b0;
        end else begin
            bdiv_cnt <= bdiv_wrap ? '0 : bdiv_cnt + 1'b1;
            if (bdiv_wrap) b_clk_r <= ~b_clk_r;
            if (bclk_fall) begin
                bit_cnt <= bit_nxt;
                lr_r    <= lr_of(bit_nxt, fmt_nxt);
            end
        end
    end

    // Frame format register, updated only at frame boundaries.
    always_ff @(posedge clk) begin
        if (!reset)          fmt_q <= FMT_LJ;
        else if (frame_tick) fmt_q <= fmt;
    end

    // Transmit-word source for the next frame.
    // An empty DAC FIFO reads as zero, which is the underrun fill value.
    always_comb begin
        tx_load      = dac_head;
        dac_pop      = frame_tick;
        underrun_set = frame_tick && dac_empty;
`ifdef AUDIO_LOOPBACK_EN
        if (loopback) begin
            tx_load      = cap_word;
            dac_pop      = 1'b0;
            underrun_set = 1'b0;
        end
`endif
    end

`ifndef AUDIO_LOOPBACK_EN
    logic unused_loopback;
    assign unused_loopback = loopback;
`endif

    // Transmit word and serial DAC output, both advanced on b_clk falling edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_word  <= '0;
            dacdat_r <= 1'b0;
        end else if (!en) begin
            dacdat_r <= 1'b0;
        end else if (frame_tick) begin
            tx_word  <= tx_load;
            dacdat_r <= slot_bit(tx_load, '0, fmt);
        end else if (bclk_fall) begin
            dacdat_r <= slot_bit(tx_word, bit_nxt, fmt_q);
        end
    end

    // ADC capture on b_clk rising edges. The word is pushed and cleared at each frame boundary.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            cap_word <= '0;
        end else if (frame_tick) begin
            cap_word <= '0;
        end else if (bclk_rise && slot_hit(bit_cnt, fmt_q)) begin
            cap_word[slot_idx(bit_cnt, fmt_q)] <= adcdat;
        end
    end

    // A user pop in the same cycle makes room, so only a push into a full FIFO with no pop is dropped.
    assign overrun_set = frame_tick && adc_fifo_full && !rd_adc_fifo;

    // Sticky error flags. Setting wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dac_underrun_r <= 1'b0;
            adc_overrun_r  <= 1'b0;
        end else begin
            dac_underrun_r <= underrun_set || (dac_underrun_r && !clr_flags);
            adc_overrun_r  <= overrun_set  || (adc_overrun_r  && !clr_flags);
        end
    end

    sync_fifo #(.WIDTH(WORD_W), .AW(FIFO_AW)) u_dac_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_dac_fifo),
        .push_data (dac_fifo_in),
        .pop       (dac_pop),
        .pop_data  (dac_head),
        .empty     (dac_empty),
        .full      (dac_fifo_full)
    );

    sync_fifo #(.WIDTH(WORD_W), .AW(FIFO_AW)) u_adc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (frame_tick),
        .push_data (cap_word),
        .pop       (rd_adc_fifo),
        .pop_data  (adc_fifo_out),
        .empty     (adc_fifo_empty),
        .full      (adc_fifo_full)
    );

    assign m_clk        = m_clk_r;
    assign b_clk        = b_clk_r;
    assign dac_lr_clk   = lr_r;
    assign adc_lr_clk   = lr_r;
    assign dacdat       = dacdat_r;
    assign dac_underrun = dac_underrun_r;
    assign adc_overrun  = adc_overrun_r;

endmodule

// File: tb/tb_audio_serial_port.sv
// Randomised bench for audio_serial_port with a frame-level reference model.
module tb_audio_serial_port;

    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;
    localparam int MCLK_DIV = 2;
    localparam int BCLK_DIV = 4;
    localparam int FIFO_AW  = 2;
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int FRAME    = 2*SLOT_W;
    localparam int FRAME_CYC = FRAME*2*BCLK_DIV;
`ifdef AUDIO_LOOPBACK_EN
    localparam bit LB_BUILD = 1'b1;
`else
    localparam bit LB_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        fmt = 1'b0;
    logic        loopback = 1'b0;
    logic        clr_flags = 1'b0;
    logic        adcdat = 1'b0;
    logic [31:0] dac_fifo_in = '0;
    logic        wr_dac_fifo = 1'b0;
    logic        rd_adc_fifo = 1'b0;
    logic        m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat;
    logic        dac_fifo_full, adc_fifo_empty, adc_fifo_full;
    logic        dac_underrun, adc_overrun;
    logic [31:0] adc_fifo_out;

    audio_serial_port #(
        .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .MCLK_DIV(MCLK_DIV),
        .BCLK_DIV(BCLK_DIV), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .fmt(fmt), .loopback(loopback),
        .clr_flags(clr_flags), .adcdat(adcdat), .m_clk(m_clk), .b_clk(b_clk),
        .dac_lr_clk(dac_lr_clk), .adc_lr_clk(adc_lr_clk), .dacdat(dacdat),
        .dac_fifo_in(dac_fifo_in), .wr_dac_fifo(wr_dac_fifo),
        .dac_fifo_full(dac_fifo_full), .adc_fifo_out(adc_fifo_out),
        .rd_adc_fifo(rd_adc_fifo), .adc_fifo_empty(adc_fifo_empty),
        .adc_fifo_full(adc_fifo_full), .dac_underrun(dac_underrun),
        .adc_overrun(adc_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] dac_q[$];
    logic [31:0] adc_q[$];
    logic [31:0] dir_dac[$];
    logic [31:0] dir_adc[$];
    logic [31:0] cur_tx, cur_adc;
    logic        cur_fmt, exp_und, exp_ovr, prev_bclk, prev_mclk;
    int          pos, cyc, last_mclk, last_fall, mclk_checks, bclk_checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, frame bit %0d)", tag, obs, exp_v, cyc, pos);
        end
    endtask

    // Sample bit carried at frame position p: left half in the first slot, right half in the second.
    function automatic logic exp_bit(input logic [31:0] w, input int p, input logic f);
        logic [15:0] smp;
        int rel;
        smp = (p < SLOT_W) ? w[31:16] : w[15:0];
        rel = (p % SLOT_W) - (f ? 1 : 0);
        if (rel < 0 || rel >= SAMPLE_W) return 1'b0;
        return smp[SAMPLE_W-1-rel];
    endfunction

    function automatic logic exp_lr(input int p, input logic f);
        if (f) return (p >= SLOT_W-1) && (p < FRAME-1);
        return p >= SLOT_W;
    endfunction

    function automatic logic [31:0] next_adc_word();
        if (dir_adc.size() > 0) return dir_adc.pop_front();
        return $urandom();
    endfunction

    // Advance one clock. Apply the inputs sampled at the last rising edge to the model, then compare.
    task automatic step();
        logic fell, rose, tick, und_set, ovr_set;
        @(negedge clk);
        cyc++;
        fell = prev_bclk && !b_clk;
        rose = !prev_bclk && b_clk;
        prev_bclk = b_clk;
        und_set = 1'b0;
        ovr_set = 1'b0;
        if (m_clk !== prev_mclk) begin
            if (last_mclk >= 0 && mclk_checks < 16) begin
                chk("mclk_half_period", cyc - last_mclk, MCLK_DIV);
                mclk_checks++;
            end
            last_mclk = cyc;
            prev_mclk = m_clk;
        end
        if (fell) begin
            if (last_fall >= 0 && bclk_checks < 16) begin
                chk("bclk_period", cyc - last_fall, 2*BCLK_DIV);
                bclk_checks++;
            end
            last_fall = cyc;
        end
        tick = fell && (pos == FRAME-1);
        if (rd_adc_fifo && adc_q.size() > 0) void'(adc_q.pop_front());
        if (tick) begin
            if (LB_BUILD && loopback) cur_tx = cur_adc;
            else if (dac_q.size() > 0) cur_tx = dac_q.pop_front();
            else begin
                cur_tx = '0;
                und_set = 1'b1;
            end
            if (adc_q.size() < DEPTH) adc_q.push_back(cur_adc);
            else ovr_set = 1'b1;
            cur_fmt = fmt;
            cur_adc = next_adc_word();
        end
        if (wr_dac_fifo && dac_q.size() < DEPTH) dac_q.push_back(dac_fifo_in);
        if (clr_flags) begin
            exp_und = 1'b0;
            exp_ovr = 1'b0;
        end
        if (und_set) exp_und = 1'b1;
        if (ovr_set) exp_ovr = 1'b1;
        if (fell) begin
            pos = (pos + 1) % FRAME;
            adcdat = exp_bit(cur_adc, pos, cur_fmt);
        end
        if (rose) begin
            chk("dacdat", dacdat, exp_bit(cur_tx, pos, cur_fmt));
            chk("dac_lr_clk", dac_lr_clk, exp_lr(pos, cur_fmt));
            chk("adc_lr_clk", adc_lr_clk, exp_lr(pos, cur_fmt));
        end
        chk("dac_underrun", dac_underrun, exp_und);
        chk("adc_overrun", adc_overrun, exp_ovr);
        chk("dac_fifo_full", dac_fifo_full, dac_q.size() == DEPTH);
        chk("adc_fifo_empty", adc_fifo_empty, adc_q.size() == 0);
        chk("adc_fifo_full", adc_fifo_full, adc_q.size() == DEPTH);
        chk("adc_fifo_out", adc_fifo_out, (adc_q.size() > 0) ? adc_q[0] : 32'h0);
    endtask

    // Random user-side stimulus; probabilities are per mille.
    task automatic drive(input int p_wr, input int p_rd, input int p_fmt);
        wr_dac_fifo = ($urandom_range(999) < p_wr);
        if (wr_dac_fifo) dac_fifo_in = (dir_dac.size() > 0) ? dir_dac.pop_front() : $urandom();
        rd_adc_fifo = ($urandom_range(999) < p_rd);
        clr_flags   = ($urandom_range(999) < 3);
        if ($urandom_range(999) < p_fmt) fmt = ~fmt;
        if (!LB_BUILD) loopback = $urandom_range(1);
    endtask

    task automatic run_frames(input int n, input int p_wr, input int p_rd, input int p_fmt);
        repeat (n*FRAME_CYC) begin
            step();
            drive(p_wr, p_rd, p_fmt);
        end
    endtask

    // Reset with checks of every reset value, then re-enable and time the first b_clk edge.
    task automatic do_reset();
        int k;
        reset = 1'b0;
        en = 1'b0;
        wr_dac_fifo = 1'b0;
        rd_adc_fifo = 1'b0;
        clr_flags = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_m_clk", m_clk, 1'b0);
        chk("rst_b_clk", b_clk, 1'b0);
        chk("rst_dac_lr", dac_lr_clk, 1'b0);
        chk("rst_adc_lr", adc_lr_clk, 1'b0);
        chk("rst_dacdat", dacdat, 1'b0);
        chk("rst_underrun", dac_underrun, 1'b0);
        chk("rst_overrun", adc_overrun, 1'b0);
        chk("rst_adc_out", adc_fifo_out, 32'h0);
        chk("rst_adc_empty", adc_fifo_empty, 1'b1);
        chk("rst_adc_full", adc_fifo_full, 1'b0);
        chk("rst_dac_full", dac_fifo_full, 1'b0);
        dac_q.delete();
        adc_q.delete();
        cur_tx = '0;
        cur_fmt = 1'b0;
        exp_und = 1'b0;
        exp_ovr = 1'b0;
        prev_bclk = 1'b0;
        prev_mclk = 1'b0;
        pos = 0;
        last_mclk = -1;
        last_fall = -1;
        reset = 1'b1;
        step();
        en = 1'b1;
        cur_adc = next_adc_word();
        adcdat = exp_bit(cur_adc, 0, cur_fmt);
        k = 0;
        while (b_clk !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk("first_bclk_rise", k, BCLK_DIV);
    endtask

    initial begin
        cyc = 0;
        mclk_checks = 0;
        bclk_checks = 0;
        fmt = 1'b0;
        dir_dac.push_back({16'hA5C3, 16'h1234});
        do_reset();
        // Left-justified traffic; the directed word goes out in the second frame.
        run_frames(3, 10, 20, 0);
        // I2S with a directed ADC word.
        fmt = 1'b1;
        dir_adc.push_back({16'h8001, 16'h7FFE});
        run_frames(3, 10, 20, 0);
        // No DAC writes: underrun frames.
        run_frames(2, 0, 20, 0);
        // Never read: the ADC FIFO fills and overruns.
        run_frames(6, 10, 0, 0);
        // Drain the ADC FIFO.
        run_frames(1, 10, 250, 0);
        // Mixed traffic with format changes at arbitrary points.
        run_frames(6, 20, 30, 2);
`ifdef AUDIO_LOOPBACK_EN
        fmt = 1'b0;
        dir_adc.push_back(32'hDEADBEEF);
        loopback = 1'b1;
        run_frames(3, 5, 30, 0);
        loopback = 1'b0;
`endif
        // Reset in the middle of a frame, then resume.
        repeat (200) begin
            step();
            drive(20, 30, 0);
        end
        do_reset();
        run_frames(2, 20, 30, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_serial_port.md
# audio_serial_port

Parametrised codec audio port: generates the codec master, bit and L/R clocks from the system clock, and serialises stereo DAC samples from a write-side FIFO. It also deserialises stereo ADC samples into a read-side FIFO. It succeeds the fixed 32-bit WM8731 data path and adds:
- configurable sample width, slot width, clock dividers and FIFO depth;
- runtime left-justified / I2S format selection;
- underrun/overrun flags and an optional loopback.

It sits between the user logic and the codec pins, next to the I2C configuration block.

## Interface
- SAMPLE_W, 16, bits per channel sample (16..32)
- SLOT_W, 32, b_clk periods per channel slot (≥ SAMPLE_W)
- MCLK_DIV, 2, clk cycles per m_clk half-period (≥1)
- BCLK_DIV, 4, clk cycles per b_clk half-period (≥2)
- FIFO_AW, 4, log2 FIFO depth (both FIFOs)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  port enable; low stops b_clk/lr framing
- fmt  in  1  0 = left-justified, 1 = I2S
- loopback  in  1  ADC→DAC loopback request (used only with macro)
- clr_flags  in  1  clears sticky flags
- adcdat  in  1  codec ADC serial data
- m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat  out  1 each  codec pins
- dac_fifo_in  in  2*SAMPLE_W  {left,right} sample
- wr_dac_fifo  in  1  push; ignored when dac_fifo_full
- dac_fifo_full  out  1
- adc_fifo_out  out  2*SAMPLE_W  {left,right}, valid when !adc_fifo_empty
- rd_adc_fifo  in  1  pop; ignored when adc_fifo_empty
- adc_fifo_empty, adc_fifo_full  out  1
- dac_underrun, adc_overrun  out  1  sticky error flags

## Operation
- **m_clk:** free-running; toggles every MCLK_DIV clk cycles, including when en=0.
- **b_clk divider:** counts 0..BCLK_DIV-1 and toggles b_clk on wrap. It runs only while en=1; en=0 zeroes the divider, bit counter, b_clk and lr.
- **Frame:** 2*SLOT_W b_clk periods; bit counter 0..2*SLOT_W-1 advances on each b_clk falling edge.
- **L/R clock:** dac_lr_clk = adc_lr_clk = lr; lr=0 while bit counter < SLOT_W (left), 1 otherwise.
  - In I2S mode lr changes one b_clk period early, i.e. at slot-relative bit SLOT_W-1.
- **Data placement:** in slot-relative bits, MSB at bit 0 (fmt=0) or bit 1 (fmt=1), followed by SAMPLE_W-1 further bits MSB-first. Positions past slot end are truncated. Remaining slot bits transmit 0 and are ignored on capture.
- **dacdat timing:** updates on b_clk falling edges.
- **adcdat capture:** sampled on b_clk rising edges into a 2*SAMPLE_W shift register.
- **Frame boundary** (b_clk falling edge where the bit counter wraps to 0): a one-cycle internal frame_tick.
  - **DAC side:** if the DAC FIFO is non-empty, pop into the transmit register. If empty, load 0 and set dac_underrun.
  - **ADC side:** push the completed capture register. If the ADC FIFO is full, drop the word and set adc_overrun.
- **fmt changes:** sampled only at frame_tick and applied to the next frame.
- **Flags:** clr_flags clears both flags; a set and clr_flags in the same cycle leaves the flag set.
- **FIFO:** a simultaneous user push and pop on the same FIFO are both honoured when it is neither empty nor full. On a full FIFO, push+pop is allowed (the pop frees space).

## Timing
- **Reset values:** m_clk, b_clk, lr, dacdat, dac_underrun, adc_overrun = 0; adc_fifo_out = 0; *_empty = 1; *_full = 0; all counters = 0.
- **First b_clk edge:** rising, BCLK_DIV cycles after en rises.
- **DAC latency:** a word present at frame_tick drives its first bit on dacdat in the same clk cycle as that tick, i.e. bit 0 of the new frame.
- **ADC latency:** adc_fifo_empty deasserts 1 clk after frame_tick. The FIFO is first-word-fall-through: adc_fifo_out shows the head word combinationally from registered storage.
- **Empty/full:** full/empty update the cycle after the push/pop.
- **Reset mid-frame:** discards partial words and FIFO contents.

## Configuration
- `AUDIO_LOOPBACK_EN` defined, loopback=1: at frame_tick the captured ADC word is loaded into the DAC transmit register instead of a DAC FIFO pop.
  - The DAC FIFO is untouched and no underrun is flagged.
  - The ADC push still occurs.
- Macro undefined: the loopback port is ignored and no loopback mux is synthesised.

## Structure
- **Package audio_pkg:** FMT_LJ = 1'b0, FMT_I2S = 1'b1, and a function computing the MSB bit offset from fmt.
- **Sub-module sync_fifo:** parametrised synchronous FWFT FIFO (width, FIFO_AW), instantiated twice (DAC, ADC). Counters and serdes stay in the top level.

## Test plan
1. **Reset:** hold reset=0 5 cycles → all outputs at reset values; release with en=1, BCLK_DIV=4 → b_clk period 8 clk; lr toggles every 32 b_clk periods.
2. **Left-justified DAC, fmt=0:** push {16'hA5C3,16'h1234} → dacdat bit 0 of next frame = 1 (MSB of A5C3); right slot bits 32..47 = 1234; slot bits 16..31 and 48..63 = 0.
3. **I2S ADC, fmt=1:** drive adcdat with left=16'h8001, right=16'h7FFE, MSB at slot bit 1 → adc_fifo_out = 32'h80017FFE; adc_fifo_empty falls 1 clk after frame end.
4. **DAC underrun:** DAC FIFO empty at frame boundary → dacdat 0 for the whole frame, dac_underrun=1 until clr_flags.
5. **ADC overrun:** never read, FIFO_AW=2 → after the 5th frame adc_overrun=1; the 4 stored words are the first 4 frames.
6. **Loopback:** with `AUDIO_LOOPBACK_EN`, loopback=1, adcdat pattern 32'hDEADBEEF → the next frame's dacdat carries DEAD/BEEF; DAC FIFO level unchanged.
